f_fetch: RTL and testbench
==========================

Name: f_fetch

Overview:
- IF stage of the 5-stage MIPS pipeline. Holds the PC, reads the instruction ROM, and presents `f_instr`/`f_pc` to the IF/ID pipeline register, which samples them on the next clock edge.
- Stall comes from the hazard unit. Branch/jump redirect comes from the D stage, which resolves branches and has a single delay slot.
- Also keeps a fetch counter for performance tracing.

Parameters:
- PC_INIT, 32'h0000_3000, PC value after reset.
- IM_BASE, 32'h0000_3000, byte address of ROM word 0.
- IM_DEPTH, 4096, ROM depth in 32-bit words.
- IM_FILE, "code.txt", hex image loaded with $readmemh at time 0.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  1 = advance PC; 0 = stall (hold PC and counter).
- d_redirect  in  1  D stage requests a PC change (taken branch, j/jal/jr).
- d_target  in  32  next-PC target from the D stage; valid when d_redirect=1.
- f_pc  out  32  PC of the instruction currently being fetched.
- f_instr  out  32  instruction word at f_pc.
- f_pc8  out  32  f_pc + 8 (link value forwarded for jal/jalr).
- fetch_cnt  out  32  count of fetches accepted since reset.

Behaviour:
- PC register
  - Asynchronous reset: f_pc = PC_INIT and fetch_cnt = 0 immediately while reset=1, independent of clk.
  - On posedge clk with reset=0:
    - en=0 → PC holds and fetch_cnt holds; d_redirect is ignored.
    - en=1, d_redirect=1 → PC ← d_target.
    - en=1, d_redirect=0 → PC ← PC + 4 (32-bit, wraps modulo 2^32).
  - Priority: reset > stall > redirect > sequential.
- Stall/redirect interaction
  - A branch stalled in D has unresolved operands, so its redirect must not take effect.
  - When en returns to 1, the redirect is applied on that edge if d_redirect is still asserted.
- Delay slot
  - When d_redirect is sampled, the instruction in F is the delay-slot instruction.
  - It is always fetched and passed on; no flush output.
- ROM read
  - Combinational, zero latency.
  - index = (f_pc − IM_BASE) >> 2, using bits [13:2] for the default depth.
  - f_instr = ROM[index], valid in the same cycle f_pc changes.
- f_pc8 is combinational: f_pc + 8.
- fetch_cnt
  - Increments by 1 on each posedge with en=1 and reset=0.
  - Wraps from 32'hFFFF_FFFF to 0.
- Reset mid-operation
  - PC and counter return asynchronously to their reset values.
  - Pending redirect and stall are discarded.
  - On the first edge after deassertion, the normal rules apply from PC_INIT.
- Reset values: f_pc = PC_INIT; f_instr = ROM[0]; f_pc8 = PC_INIT + 8; fetch_cnt = 0.

Optional Feature:
- Macro: F_ADDR_CHECK_EN.
- Defined:
  - Fetch is illegal if f_pc[1:0] != 0 or f_pc is outside [IM_BASE, IM_BASE + 4*IM_DEPTH).
  - On an illegal fetch, f_instr = 32'h0000_0000 (nop) instead of ROM data.
  - An extra output f_adel (1 bit) is 1 while the fetch is illegal, 0 otherwise; reset value 0.
  - The PC still updates per the normal rules.
- Undefined:
  - No f_adel port.
  - The index is truncated to the ROM address bits with no check, so out-of-range PCs alias into the ROM.

Test Plan:
- Reset then 3 cycles with en=1 and no redirect → f_pc = 3000, 3004, 3008, 300C; fetch_cnt = 0, 1, 2, 3; f_instr matches ROM[0..3].
- At f_pc = 3008, set en=0 for 2 cycles → f_pc stays 3008 and fetch_cnt holds; on release, f_pc → 300C.
- At f_pc = 3010, d_redirect=1 with d_target = 3100 for one cycle → next f_pc = 3100; the following cycle f_pc = 3104.
- Simultaneous en=0, d_redirect=1, d_target = 3200 → PC holds for that cycle; next cycle with en=1 and redirect still high → f_pc = 3200.
- Assert reset asynchronously mid-cycle at f_pc = 3104 → f_pc = 3000 and fetch_cnt = 0 before the next clock edge; f_pc8 = 3008.
- With F_ADDR_CHECK_EN, redirect to 3002, then to 7000 → f_adel = 1 and f_instr = 0 in both cases; redirect to 3004 → f_adel = 0.

Source files
------------

// File: rtl/f_fetch.sv
// IF stage: PC register, combinational instruction ROM read, PC+8 link value and fetch counter.
// Optional fetch address checking (nop substitution plus f_adel flag) is enabled by defining F_ADDR_CHECK_EN.
module f_fetch #(
  parameter logic [31:0] PC_INIT  = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          IM_DEPTH = 4096,
  parameter string       IM_FILE  = "code.txt"
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        d_redirect,
  input  logic [31:0] d_target,
  output logic [31:0] f_pc,
  output logic [31:0] f_instr,
  output logic [31:0] f_pc8,
`ifdef F_ADDR_CHECK_EN
  output logic        f_adel,
`endif
  output logic [31:0] fetch_cnt
);

  localparam int AW = $clog2(IM_DEPTH);

  logic [31:0]   r_pc;
  logic [31:0]   r_cnt;
  logic [31:0]   r_rom [IM_DEPTH];
  logic [31:0]   w_off;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rdata;

  // Stall beats redirect: a branch stalled in D has unresolved operands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc  <= PC_INIT;
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + 32'd1;
      r_pc  <= d_redirect ? d_target : r_pc + 32'd4;
    end
  end

  assign w_off   = r_pc - IM_BASE;
  assign w_idx   = AW'(w_off >> 2);
  assign w_rdata = r_rom[w_idx];

`ifdef F_ADDR_CHECK_EN
  localparam logic [32:0] IM_BYTES = 33'(IM_DEPTH) * 33'd4;
  logic w_misalign;
  logic w_outside;

  // The offset wraps below IM_BASE, so one unsigned compare covers both range ends.
  assign w_misalign = |r_pc[1:0];
  assign w_outside  = {1'b0, w_off} >= IM_BYTES;
  assign f_adel     = w_misalign | w_outside;
  assign f_instr    = f_adel ? 32'h0000_0000 : w_rdata;
`else
  assign f_instr    = w_rdata;
`endif

  assign f_pc      = r_pc;
  assign f_pc8     = r_pc + 32'd8;
  assign fetch_cnt = r_cnt;

endmodule

// File: tb/tb_f_fetch.sv
// Bench for f_fetch: directed plan steps then random en/redirect traffic against a PC/ROM reference model.
module tb_f_fetch;
  localparam logic [31:0] PC_INIT  = 32'h0000_3000;
  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam int          IM_DEPTH = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        d_redirect = 1'b0;
  logic [31:0] d_target = '0;
  logic [31:0] f_pc, f_instr, f_pc8, fetch_cnt;
`ifdef F_ADDR_CHECK_EN
  logic        f_adel;
`endif

  f_fetch #(.PC_INIT(PC_INIT), .IM_BASE(IM_BASE), .IM_DEPTH(IM_DEPTH), .IM_FILE("")) dut (
    .clk(clk), .reset(reset), .en(en), .d_redirect(d_redirect), .d_target(d_target),
    .f_pc(f_pc), .f_instr(f_instr), .f_pc8(f_pc8),
`ifdef F_ADDR_CHECK_EN
    .f_adel(f_adel),
`endif
    .fetch_cnt(fetch_cnt));

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rom_m [IM_DEPTH];
  logic [31:0] pc_m;
  logic [31:0] cnt_m;

  function automatic logic illegal_m(input logic [31:0] pc);
    longint unsigned p, lo, hi;
    p  = pc;
    lo = IM_BASE;
    hi = lo + 4 * IM_DEPTH;
    return (p % 4 != 0) || (p < lo) || (p >= hi);
  endfunction

  function automatic logic [31:0] instr_m(input logic [31:0] pc);
    logic [31:0] off;
    off = pc - IM_BASE;
`ifdef F_ADDR_CHECK_EN
    if (illegal_m(pc)) return 32'h0;
`endif
    return rom_m[(off / 4) % IM_DEPTH];
  endfunction

  task automatic check(input string tag);
    checks++;
    assert (f_pc === pc_m) else begin
      errors++; $error("FAIL %s f_pc got %h exp %h", tag, f_pc, pc_m);
    end
    checks++;
    assert (fetch_cnt === cnt_m) else begin
      errors++; $error("FAIL %s fetch_cnt got %0d exp %0d", tag, fetch_cnt, cnt_m);
    end
    checks++;
    assert (f_pc8 === pc_m + 32'd8) else begin
      errors++; $error("FAIL %s f_pc8 got %h exp %h", tag, f_pc8, pc_m + 32'd8);
    end
    checks++;
    assert (f_instr === instr_m(pc_m)) else begin
      errors++; $error("FAIL %s f_instr got %h exp %h", tag, f_instr, instr_m(pc_m));
    end
`ifdef F_ADDR_CHECK_EN
    checks++;
    assert (f_adel === illegal_m(pc_m)) else begin
      errors++; $error("FAIL %s f_adel got %b exp %b", tag, f_adel, illegal_m(pc_m));
    end
`endif
  endtask

  // Drive one cycle of inputs, advance the model at the edge, then compare.
  task automatic step(input logic e, input logic r, input logic [31:0] t, input string tag);
    en = e; d_redirect = r; d_target = t;
    @(posedge clk);
    if (!reset && e) begin
      cnt_m = cnt_m + 32'd1;
      pc_m  = r ? t : pc_m + 32'd4;
    end
    #1 check(tag);
  endtask

  initial begin
    for (int i = 0; i < IM_DEPTH; i++) begin
      rom_m[i] = $urandom;
      dut.r_rom[i] = rom_m[i];
    end
    pc_m = PC_INIT; cnt_m = 0;
    @(negedge clk);
    check("reset");
    @(negedge clk);
    reset = 1'b0;

    step(1, 0, 0, "seq1");
    step(1, 0, 0, "seq2");
    step(0, 0, 0, "stall1");
    step(0, 0, 0, "stall2");
    step(1, 0, 0, "release");
    step(1, 0, 0, "seq3010");
    step(1, 1, 32'h3100, "redir3100");
    step(1, 0, 0, "after_redir");

    // Asynchronous reset in the middle of a cycle, held across an edge with a pending redirect.
    #3 reset = 1'b1;
    pc_m = PC_INIT; cnt_m = 0;
    #1 check("async_rst");
    step(1, 1, 32'h3400, "rst_hold");
    @(negedge clk);
    reset = 1'b0;
    step(1, 0, 0, "post_rst");

    step(0, 1, 32'h3200, "stall_redir");
    step(1, 1, 32'h3200, "redir_after_stall");
    step(1, 1, 32'hFFFF_FFFC, "near_top");
    step(1, 0, 0, "pc_wrap");
    step(1, 1, 32'h3000 + 4 * IM_DEPTH + 32'h10, "alias_hi");
    step(1, 0, 0, "alias_next");

`ifdef F_ADDR_CHECK_EN
    step(1, 1, 32'h3002, "adel_misalign");
    step(1, 1, 32'h7000, "adel_range");
    step(1, 1, 32'h2FFC, "adel_below");
    step(1, 1, 32'h3004, "adel_ok");
`endif

    for (int n = 0; n < 300; n++) begin
      logic        e, r;
      logic [31:0] t;
      e = ($urandom_range(0, 9) < 8);
      r = ($urandom_range(0, 9) < 3);
      t = ($urandom_range(0, 9) == 0) ? $urandom
                                      : IM_BASE + 32'(4 * $urandom_range(0, IM_DEPTH - 1));
      step(e, r, t, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
